mem_port_arbiter: RTL and testbench

Single-port main-memory arbiter and sequencer for the pipelined processor. It shares the one memory port between three requesters: the SREC loader (writes only, active while `srec_parse` is high), the data-memory stage (loads and stores), and instruction fetch (reads only). It generates the pipeline `stall` that holds fetch while memory is unavailable. It sits between `processor`'s stage modules and `memory`.

---
 rtl/proc_pkg.sv | 21 ++
 rtl/mem_lat_counter.sv | 37 +++
 rtl/mem_port_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor definitions: access sizes, memory-arbiter state and owner encodings.
// Pure declarations; no latency or backpressure of its own.
package proc_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    LOAD = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter; done is high while the count sits at 1, i.e. the last wait cycle.
// Load takes effect on the next edge; clear wins over load; no backpressure.
module mem_lat_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [CNT_W-1:0] load_val,
  input  logic             clr,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load_en) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between the SREC loader, data-memory and fetch; grants are same-cycle,
// writes finish in the grant cycle, reads return rvalid MEM_LAT+1 cycles later; a denied fetch raises stall.
module mem_port_arbiter
  import proc_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              srec_parse,
  input  logic              srec_rw,
  input  logic [ADDR_W-1:0] srec_address,
  input  logic [DATA_W-1:0] srec_data_in,
  input  logic [1:0]        srec_access_size,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_address,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_rw,
  input  logic [ADDR_W-1:0] dm_address,
  input  logic [DATA_W-1:0] dm_data_in,
  input  logic [1:0]        dm_access_size,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic [1:0]        mem_access_size,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              stall
);

  localparam int CNT_W = 3;
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);
  localparam logic [STV_W-1:0] STV_SAT  = STV_W'(STARVE_MAX);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              dm_rvalid_q, dm_rvalid_d;
  logic              cnt_load, cnt_clr, cnt_done;
  logic              if_win, dm_win;

  mem_lat_counter #(.CNT_W(CNT_W)) u_lat_cnt (
    .clk      (clk),
    .reset    (reset),
    .load_en  (cnt_load),
    .load_val (LAT_LOAD),
    .clr      (cnt_clr),
    .done     (cnt_done)
  );

  // A rising srec_parse blocks new grants so no read is started only to be aborted next cycle.
  always_comb begin
    if_win = 1'b0;
    dm_win = 1'b0;
    if (!reset && state_q == IDLE && !srec_parse) begin
      if (if_req && (!dm_req || starve_q == STV_SAT)) begin
        if_win = 1'b1;
      end else if (dm_req) begin
        dm_win = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en          = 1'b0;
    mem_rw          = 1'b0;
    mem_address     = '0;
    mem_data_in     = '0;
    mem_access_size = SIZE_BYTE;
    if (!reset) begin
      if (state_q == LOAD) begin
        mem_en          = srec_rw;
        mem_rw          = srec_rw;
        mem_address     = srec_address;
        mem_data_in     = srec_data_in;
        mem_access_size = srec_access_size;
      end else if (dm_win) begin
        mem_en          = 1'b1;
        mem_rw          = dm_rw;
        mem_address     = dm_address;
        mem_data_in     = dm_data_in;
        mem_access_size = dm_access_size;
      end else if (if_win) begin
        mem_en          = 1'b1;
        mem_address     = if_address;
        mem_access_size = SIZE_WORD;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    cnt_load    = 1'b0;
    cnt_clr     = 1'b0;

    case (state_q)
      IDLE: begin
        if (srec_parse) begin
          state_d = LOAD;
        end else if (if_win || (dm_win && !dm_rw)) begin
          state_d  = BUSY;
          owner_d  = if_win ? OWN_IF : OWN_DM;
          cnt_load = 1'b1;
        end
      end
      BUSY: begin
        if (srec_parse) begin
          state_d = LOAD;
          owner_d = OWN_NONE;
          cnt_clr = 1'b1;
        end else if (cnt_done) begin
          state_d = IDLE;
          owner_d = OWN_NONE;
          if (owner_q == OWN_IF) begin
            if_rdata_d  = mem_data_out;
            if_rvalid_d = 1'b1;
          end else if (owner_q == OWN_DM) begin
            dm_rdata_d  = mem_data_out;
            dm_rvalid_d = 1'b1;
          end
        end
      end
      LOAD: begin
        cnt_clr = 1'b1;
        if (!srec_parse) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Fetch fairness: count consecutive denied fetch cycles, saturating.
    if (state_q == LOAD || if_win) begin
      starve_d = '0;
    end else if (if_req && starve_q != STV_SAT) begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      starve_q    <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
    end
  end

  assign if_gnt    = if_win;
  assign dm_gnt    = dm_win;
  assign if_rvalid = if_rvalid_q & ~reset;
  assign dm_rvalid = dm_rvalid_q & ~reset;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign stall     = reset | (state_q == LOAD) | (if_req & ~if_win);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives two arbiters (MEM_LAT 1 and 3) with directed scenarios, checks every cycle against a
// cycle-number based model of the port protocol, plus literal expectations at key cycles.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset            [2];
  logic        srec_parse       [2];
  logic        srec_rw          [2];
  logic [31:0] srec_address     [2];
  logic [31:0] srec_data_in     [2];
  logic [1:0]  srec_access_size [2];
  logic        if_req           [2];
  logic [31:0] if_address       [2];
  logic        if_gnt           [2];
  logic        if_rvalid        [2];
  logic [31:0] if_rdata         [2];
  logic        dm_req           [2];
  logic        dm_rw            [2];
  logic [31:0] dm_address       [2];
  logic [31:0] dm_data_in       [2];
  logic [1:0]  dm_access_size   [2];
  logic        dm_gnt           [2];
  logic        dm_rvalid        [2];
  logic [31:0] dm_rdata         [2];
  logic        mem_en           [2];
  logic        mem_rw           [2];
  logic [31:0] mem_address      [2];
  logic [31:0] mem_data_in      [2];
  logic [1:0]  mem_access_size  [2];
  logic [31:0] mem_data_out     [2];
  logic        stall            [2];

  int          cyc = 0;
  int          rd_cyc  [2];
  logic [31:0] rd_addr [2];
  int          n_tests = 0;
  int          n_fail  = 0;

  // Memory contents seen by reads: one known program word, otherwise address-derived.
  function automatic logic [31:0] rd_val(input logic [31:0] a);
    if (a == 32'h8002_0000) return 32'h27BD_FFF8;
    return {a[15:0], ~a[15:0]};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .MEM_LAT    ((g == 0) ? 1 : 3),
      .STARVE_MAX (STARVE_MAX)
    ) u_dut (
      .clk              (clk),
      .reset            (reset[g]),
      .srec_parse       (srec_parse[g]),
      .srec_rw          (srec_rw[g]),
      .srec_address     (srec_address[g]),
      .srec_data_in     (srec_data_in[g]),
      .srec_access_size (srec_access_size[g]),
      .if_req           (if_req[g]),
      .if_address       (if_address[g]),
      .if_gnt           (if_gnt[g]),
      .if_rvalid        (if_rvalid[g]),
      .if_rdata         (if_rdata[g]),
      .dm_req           (dm_req[g]),
      .dm_rw            (dm_rw[g]),
      .dm_address       (dm_address[g]),
      .dm_data_in       (dm_data_in[g]),
      .dm_access_size   (dm_access_size[g]),
      .dm_gnt           (dm_gnt[g]),
      .dm_rvalid        (dm_rvalid[g]),
      .dm_rdata         (dm_rdata[g]),
      .mem_en           (mem_en[g]),
      .mem_rw           (mem_rw[g]),
      .mem_address      (mem_address[g]),
      .mem_data_in      (mem_data_in[g]),
      .mem_access_size  (mem_access_size[g]),
      .mem_data_out     (mem_data_out[g]),
      .stall            (stall[g])
    );
    // Read data only appears on its due cycle; other cycles carry junk.
    assign mem_data_out[g] = (cyc == rd_cyc[g]) ? rd_val(rd_addr[g]) : (32'hBAD0_0000 ^ 32'(cyc));
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d got=%h expected=%h", name, k, cyc, got, exp);
    end
  endtask

  // Model state: loader mode is "parse was high last cycle"; an outstanding read is a due cycle number.
  logic        m_prev_parse [2];
  logic        m_pend       [2];
  int          m_due        [2];
  logic        m_own_if     [2];
  logic [31:0] m_addr       [2];
  int          m_starve     [2];
  logic [31:0] m_if_rdata   [2];
  logic [31:0] m_dm_rdata   [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int          lat;
      logic        in_load, busy, fire, can;
      logic        e_ifg, e_dmg, e_ifv, e_dmv, e_en, e_rw, e_stall;
      logic [31:0] e_addr;
      lat = (k == 0) ? 1 : 3;
      if (reset[k]) begin
        check("rst_if_gnt", k, if_gnt[k], 0);
        check("rst_dm_gnt", k, dm_gnt[k], 0);
        check("rst_if_rvalid", k, if_rvalid[k], 0);
        check("rst_dm_rvalid", k, dm_rvalid[k], 0);
        check("rst_mem_en", k, mem_en[k], 0);
        check("rst_mem_rw", k, mem_rw[k], 0);
        check("rst_stall", k, stall[k], 1);
        m_prev_parse[k] = 1'b0;
        m_pend[k]       = 1'b0;
        m_starve[k]     = 0;
        m_if_rdata[k]   = '0;
        m_dm_rdata[k]   = '0;
      end else begin
        in_load = m_prev_parse[k];
        busy    = m_pend[k] && (cyc < m_due[k]);
        fire    = m_pend[k] && (cyc == m_due[k]);
        e_ifv   = fire && m_own_if[k];
        e_dmv   = fire && !m_own_if[k];
        if (fire) begin
          if (m_own_if[k]) m_if_rdata[k] = rd_val(m_addr[k]);
          else             m_dm_rdata[k] = rd_val(m_addr[k]);
          m_pend[k] = 1'b0;
        end
        can     = !in_load && !busy && !srec_parse[k];
        e_ifg   = can && if_req[k] && (!dm_req[k] || m_starve[k] == STARVE_MAX);
        e_dmg   = can && dm_req[k] && !e_ifg;
        e_stall = in_load || (if_req[k] && !e_ifg);
        e_en    = in_load ? srec_rw[k] : (e_ifg || e_dmg);
        e_rw    = in_load ? srec_rw[k] : (e_dmg && dm_rw[k]);
        e_addr  = in_load ? srec_address[k] : (e_dmg ? dm_address[k] : if_address[k]);

        check("if_gnt", k, if_gnt[k], e_ifg);
        check("dm_gnt", k, dm_gnt[k], e_dmg);
        check("if_rvalid", k, if_rvalid[k], e_ifv);
        check("dm_rvalid", k, dm_rvalid[k], e_dmv);
        check("mem_en", k, mem_en[k], e_en);
        check("mem_rw", k, mem_rw[k], e_rw);
        check("stall", k, stall[k], e_stall);
        check("if_rdata", k, if_rdata[k], m_if_rdata[k]);
        check("dm_rdata", k, dm_rdata[k], m_dm_rdata[k]);
        if (e_en && mem_en[k]) begin
          check("mem_address", k, mem_address[k], e_addr);
          if (e_rw) check("mem_data_in", k, mem_data_in[k], in_load ? srec_data_in[k] : dm_data_in[k]);
          if (!e_ifg) check("mem_size", k, {30'd0, mem_access_size[k]},
                            {30'd0, in_load ? srec_access_size[k] : dm_access_size[k]});
        end

        if (busy && srec_parse[k]) m_pend[k] = 1'b0;
        if (e_ifg || (e_dmg && !dm_rw[k])) begin
          m_pend[k]   = 1'b1;
          m_due[k]    = cyc + lat + 1;
          m_own_if[k] = e_ifg;
          m_addr[k]   = e_addr;
        end
        if (in_load || e_ifg) m_starve[k] = 0;
        else if (if_req[k] && m_starve[k] < STARVE_MAX) m_starve[k] = m_starve[k] + 1;
        m_prev_parse[k] = srec_parse[k];
      end
      if (mem_en[k] === 1'b1 && mem_rw[k] === 1'b0) begin
        rd_cyc[k]  = cyc + lat;
        rd_addr[k] = mem_address[k];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  logic [7:0] srec_bytes [3];
  logic [6:0] st_exp_if, st_exp_dm;

  initial begin
    srec_bytes = '{8'h27, 8'hBD, 8'hFF};
    st_exp_if  = 7'b0010000;
    st_exp_dm  = 7'b1001111;
    for (int k = 0; k < 2; k++) begin
      reset[k] = 1'b1;  srec_parse[k] = 1'b0; srec_rw[k] = 1'b0;
      srec_address[k] = '0; srec_data_in[k] = '0; srec_access_size[k] = 2'b00;
      if_req[k] = 1'b0; if_address[k] = '0;
      dm_req[k] = 1'b0; dm_rw[k] = 1'b0; dm_address[k] = '0; dm_data_in[k] = '0;
      dm_access_size[k] = 2'b10;
      rd_cyc[k] = -1;   rd_addr[k] = '0;
    end
    step(); step();
    sample();
    check("reset_stall", 0, stall[0], 1);
    check("reset_mem_en", 0, mem_en[0], 0);
    step();
    reset[0] = 1'b0; reset[1] = 1'b0;

    // SREC load with a pending fetch that must never be granted
    srec_parse[0] = 1'b1; if_req[0] = 1'b1; if_address[0] = 32'h8002_0000;
    sample(); check("preload_if_gnt", 0, if_gnt[0], 0);
    step();
    for (int i = 0; i < 3; i++) begin
      srec_rw[0] = 1'b1; srec_address[0] = 32'h8002_0000 + i;
      srec_data_in[0] = {24'd0, srec_bytes[i]}; srec_access_size[0] = 2'b00;
      sample();
      check("srec_mem_en", 0, mem_en[0], 1);
      check("srec_mem_rw", 0, mem_rw[0], 1);
      check("srec_addr", 0, mem_address[0], 32'h8002_0000 + i);
      check("srec_data", 0, mem_data_in[0], {24'd0, srec_bytes[i]});
      check("srec_stall", 0, stall[0], 1);
      check("srec_if_gnt", 0, if_gnt[0], 0);
      step();
      srec_rw[0] = 1'b0;
      sample(); check("srec_gap_en", 0, mem_en[0], 0);
      step();
    end
    if_req[0] = 1'b0; srec_parse[0] = 1'b0;
    sample(); check("load_tail_stall", 0, stall[0], 1);
    step();
    srec_rw[0] = 1'b1;
    sample(); check("srec_rw_ignored", 0, mem_en[0], 0);
    step();
    srec_rw[0] = 1'b0;

    // Fetch read, MEM_LAT=1
    if_req[0] = 1'b1; if_address[0] = 32'h8002_0000;
    sample();
    check("fetch_gnt", 0, if_gnt[0], 1);
    check("fetch_stall", 0, stall[0], 0);
    check("fetch_addr", 0, mem_address[0], 32'h8002_0000);
    step();
    if_req[0] = 1'b0;
    sample(); check("fetch_c1_rvalid", 0, if_rvalid[0], 0);
    step();
    sample();
    check("fetch_c2_rvalid", 0, if_rvalid[0], 1);
    check("fetch_rdata", 0, if_rdata[0], 32'h27BD_FFF8);
    step();
    sample(); check("fetch_pulse_end", 0, if_rvalid[0], 0);
    step();

    // Simultaneous dm read and fetch
    dm_req[0] = 1'b1; dm_rw[0] = 1'b0; dm_address[0] = 32'h0000_1000;
    if_req[0] = 1'b1; if_address[0] = 32'h8002_0004;
    sample();
    check("sim_dm_gnt", 0, dm_gnt[0], 1);
    check("sim_if_lose", 0, if_gnt[0], 0);
    check("sim_stall", 0, stall[0], 1);
    step();
    dm_req[0] = 1'b0;
    sample(); check("sim_busy_stall", 0, stall[0], 1);
    step();
    sample();
    check("sim_dm_rvalid", 0, dm_rvalid[0], 1);
    check("sim_dm_rdata", 0, dm_rdata[0], 32'h1000_EFFF);
    check("sim_if_gnt", 0, if_gnt[0], 1);
    check("sim_stall_drop", 0, stall[0], 0);
    step();
    if_req[0] = 1'b0;
    step();
    sample();
    check("sim_if_rdata", 0, if_rdata[0], 32'h0004_FFFB);
    check("dm_rdata_hold", 0, dm_rdata[0], 32'h1000_EFFF);
    step();

    // Starvation: dm writes every cycle against a waiting fetch
    if_req[0] = 1'b1; if_address[0] = 32'h8002_0008;
    dm_req[0] = 1'b1; dm_rw[0] = 1'b1;
    for (int c = 0; c < 7; c++) begin
      dm_address[0] = 32'h2000 + 4 * c; dm_data_in[0] = 32'(c);
      sample();
      check("starve_if_gnt", 0, if_gnt[0], st_exp_if[c]);
      check("starve_dm_gnt", 0, dm_gnt[0], st_exp_dm[c]);
      if (c == 6) check("starve_if_rdata", 0, if_rdata[0], 32'h0008_FFF7);
      step();
      if (c == 4) if_req[0] = 1'b0;
    end
    dm_req[0] = 1'b0; dm_rw[0] = 1'b0;

    // Reset in the middle of a read
    dm_req[0] = 1'b1; dm_address[0] = 32'h0000_1004;
    sample(); check("rst_dm_gnt0", 0, dm_gnt[0], 1);
    step();
    dm_req[0] = 1'b0; reset[0] = 1'b1;
    sample();
    check("midrst_stall", 0, stall[0], 1);
    check("midrst_mem_en", 0, mem_en[0], 0);
    step();
    reset[0] = 1'b0;
    sample();
    check("postrst_no_rvalid", 0, dm_rvalid[0], 0);
    check("postrst_rdata", 0, dm_rdata[0], 32'h0);
    step();
    if_req[0] = 1'b1; if_address[0] = 32'h8002_0000;
    sample(); check("postrst_if_gnt", 0, if_gnt[0], 1);
    step();
    if_req[0] = 1'b0;
    step();
    sample();
    check("postrst_if_rvalid", 0, if_rvalid[0], 1);
    check("postrst_if_rdata", 0, if_rdata[0], 32'h27BD_FFF8);
    step();

    // Abort a MEM_LAT=3 read by entering loader mode
    dm_req[1] = 1'b1; dm_rw[1] = 1'b0; dm_address[1] = 32'h0000_3000;
    sample(); check("abort_dm_gnt", 1, dm_gnt[1], 1);
    step();
    dm_req[1] = 1'b0; srec_parse[1] = 1'b1;
    sample(); check("abort_c1_rvalid", 1, dm_rvalid[1], 0);
    step();
    for (int i = 0; i < 5; i++) begin
      sample();
      check("abort_no_rvalid", 1, dm_rvalid[1], 0);
      check("abort_load_stall", 1, stall[1], 1);
      step();
    end
    srec_parse[1] = 1'b0;
    sample(); check("abort_load_tail", 1, stall[1], 1);
    step();
    sample(); check("abort_idle_stall", 1, stall[1], 0);
    step();
    dm_req[1] = 1'b1; dm_address[1] = 32'h0000_3004;
    sample(); check("abort_new_gnt", 1, dm_gnt[1], 1);
    step();
    dm_req[1] = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      sample();
      check("abort_new_rvalid", 1, dm_rvalid[1], (i == 4) ? 1 : 0);
      if (i == 4) check("abort_new_rdata", 1, dm_rdata[1], 32'h3004_CFFB);
      step();
    end

    step(); step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
